// File: rtl/axi_pkg.sv
// Shared AXI4 constants, responder FSM state type and the burst address-step helper.
package axi_pkg;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_DATA,
    WR_RESP
  } axi_slv_state_e;

  // WRAP keeps the address inside an aligned (len+1)<<size window; legality is judged by the caller.
  function automatic logic [63:0] next_addr(input logic [63:0] addr, input logic [2:0] size,
                                            input logic [7:0] len, input logic [1:0] burst);
    logic [63:0] step;
    logic [63:0] mask;
    step = 64'd1 << size;
    mask = ((64'(len) + 64'd1) << size) - 64'd1;
    case (burst)
      AXI_BURST_INCR: next_addr = addr + step;
      AXI_BURST_WRAP: next_addr = (addr & ~mask) | ((addr + step) & mask);
      default:        next_addr = addr;
    endcase
  endfunction

endpackage

// File: rtl/axi4_if.sv
// AXI4 bus bundle (AW/W/B/AR/R) with master and slave views.
interface axi4_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4
);
  logic [ID_WIDTH-1:0]     awid;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic                    awvalid;
  logic                    awready;

  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;

  logic [ID_WIDTH-1:0]     bid;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;

  logic [ID_WIDTH-1:0]     arid;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic                    arvalid;
  logic                    arready;

  logic [ID_WIDTH-1:0]     rid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic                    rvalid;
  logic                    rready;

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
    input  wdata, wstrb, wlast, wvalid, output wready,
    output bid, bresp, bvalid, input bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid, output arready,
    output rid, rdata, rresp, rlast, rvalid, input rready
  );

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid, input awready,
    output wdata, wstrb, wlast, wvalid, input wready,
    input  bid, bresp, bvalid, output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid, input arready,
    input  rid, rdata, rresp, rlast, rvalid, output rready
  );
endinterface

// File: rtl/sram_sp.sv
// Single-port synchronous SRAM: byte-strobe writes, one-cycle registered read, contents never reset.
module sram_sp #(
  parameter int DEPTH = 4096,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     en,
  input  logic                     we,
  input  logic [WIDTH/8-1:0]       be,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int b = 0; b < WIDTH / 8; b++) begin
          if (be[b]) begin
            mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
          end
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/axi4_sram_slave.sv
// AXI4 responder over a single-port SRAM, one transaction at a time, FIXED/INCR bursts.
// Define AXI_SLV_WRAP_EN to accept WRAP bursts of 2/4/8/16 beats; otherwise WRAP answers SLVERR.
module axi4_sram_slave
  import axi_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ID_WIDTH   = 4,
  parameter logic [ADDR_WIDTH-1:0] MEM_BASE   = 32'h8000_0000,
  parameter int                    MEM_DEPTH  = 4096
) (
  input logic   clk,
  input logic   rst_n,
  axi4_if.slave s_axi
);

  localparam int BYTES  = DATA_WIDTH / 8;
  localparam int OFFS_W = $clog2(BYTES);
  localparam int IDX_W  = $clog2(MEM_DEPTH);
  localparam logic [ADDR_WIDTH:0] MEM_END =
    {1'b0, MEM_BASE} + (ADDR_WIDTH + 1)'(MEM_DEPTH * BYTES);

  axi_slv_state_e state_q, state_d;

  logic [ID_WIDTH-1:0]   id_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] addr_nx;
  logic [7:0]            len_q;
  logic [7:0]            beat_q;
  logic [2:0]            size_q;
  logic [1:0]            burst_q;
  logic                  err_q;

  logic                  addr_err, size_err, burst_err, wrap_ok, cur_err;
  logic                  last_beat, wlast_err;
  logic                  ar_hs, aw_hs, r_hs, w_hs;
  logic                  sram_en, sram_we;
  logic [IDX_W-1:0]      mem_idx;
  logic [DATA_WIDTH-1:0] sram_rdata;

`ifdef AXI_SLV_WRAP_EN
  assign wrap_ok = (len_q == 8'd1) || (len_q == 8'd3) || (len_q == 8'd7) || (len_q == 8'd15);
`else
  assign wrap_ok = 1'b0;
`endif

  // Error status of the beat at addr_q, folded with anything already seen in this transaction.
  assign addr_err  = ({1'b0, addr_q} < {1'b0, MEM_BASE}) || ({1'b0, addr_q} >= MEM_END);
  assign size_err  = size_q > 3'(OFFS_W);
  assign burst_err = (burst_q == 2'b11) || ((burst_q == AXI_BURST_WRAP) && !wrap_ok);
  assign cur_err   = err_q || addr_err || size_err || burst_err;

  assign last_beat = (beat_q == len_q);
  assign wlast_err = (s_axi.wlast != last_beat);
  assign mem_idx   = IDX_W'((addr_q - MEM_BASE) >> OFFS_W);
  assign addr_nx   = ADDR_WIDTH'(next_addr(64'(addr_q), size_q, len_q, burst_q));

  assign ar_hs = (state_q == IDLE) && s_axi.arvalid;
  assign aw_hs = (state_q == IDLE) && s_axi.awvalid && !s_axi.arvalid;
  assign r_hs  = (state_q == RD_DATA) && s_axi.rready;
  assign w_hs  = (state_q == WR_DATA) && s_axi.wvalid;

  assign s_axi.bid = id_q;
  assign s_axi.rid = id_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      id_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      size_q  <= '0;
      burst_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (ar_hs) begin
        id_q    <= s_axi.arid;
        addr_q  <= s_axi.araddr;
        len_q   <= s_axi.arlen;
        size_q  <= s_axi.arsize;
        burst_q <= s_axi.arburst;
        beat_q  <= '0;
        err_q   <= 1'b0;
      end else if (aw_hs) begin
        id_q    <= s_axi.awid;
        addr_q  <= s_axi.awaddr;
        len_q   <= s_axi.awlen;
        size_q  <= s_axi.awsize;
        burst_q <= s_axi.awburst;
        beat_q  <= '0;
        err_q   <= 1'b0;
      end else if (r_hs || w_hs) begin
        // A wlast mismatch poisons the rest of the write burst as well as its response.
        err_q <= cur_err || (w_hs && wlast_err);
        if (!last_beat) begin
          addr_q <= addr_nx;
          beat_q <= beat_q + 8'd1;
        end
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    s_axi.arready = 1'b0;
    s_axi.awready = 1'b0;
    s_axi.wready  = 1'b0;
    s_axi.bvalid  = 1'b0;
    s_axi.bresp   = AXI_RESP_OKAY;
    s_axi.rvalid  = 1'b0;
    s_axi.rlast   = 1'b0;
    s_axi.rresp   = AXI_RESP_OKAY;
    s_axi.rdata   = '0;
    sram_en       = 1'b0;
    sram_we       = 1'b0;
    case (state_q)
      IDLE: begin
        s_axi.arready = rst_n;
        s_axi.awready = rst_n && !s_axi.arvalid;
        if (ar_hs) begin
          state_d = RD_ADDR;
        end else if (aw_hs) begin
          state_d = WR_DATA;
        end
      end
      RD_ADDR: begin
        sram_en = !cur_err;
        state_d = RD_DATA;
      end
      RD_DATA: begin
        s_axi.rvalid = 1'b1;
        s_axi.rlast  = last_beat;
        s_axi.rresp  = cur_err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
        s_axi.rdata  = cur_err ? '0 : sram_rdata;
        if (r_hs) begin
          state_d = last_beat ? IDLE : RD_ADDR;
        end
      end
      WR_DATA: begin
        s_axi.wready = 1'b1;
        if (w_hs) begin
          sram_en = !cur_err;
          sram_we = !cur_err;
          if (last_beat) begin
            state_d = WR_RESP;
          end
        end
      end
      WR_RESP: begin
        s_axi.bvalid = 1'b1;
        s_axi.bresp  = err_q ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
        if (s_axi.bready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  sram_sp #(
    .DEPTH(MEM_DEPTH),
    .WIDTH(DATA_WIDTH)
  ) u_sram (
    .clk   (clk),
    .en    (sram_en),
    .we    (sram_we),
    .be    (s_axi.wstrb),
    .addr  (mem_idx),
    .wdata (s_axi.wdata),
    .rdata (sram_rdata)
  );

endmodule

// File: tb/tb_axi4_sram_slave.sv
// Directed plus randomized bench for axi4_sram_slave against a byte-level memory model.
// Honours AXI_SLV_WRAP_EN the same way as the design build.
module tb_axi4_sram_slave;

  localparam logic [31:0] MEM_BASE  = 32'h8000_0000;
  localparam int          MEM_DEPTH = 4096;
  localparam longint      MEM_BYTES = MEM_DEPTH * 4;
  localparam int          TIMEOUT   = 200;
  localparam logic [1:0]  FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  axi4_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4)) bus ();

  axi4_sram_slave #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4),
    .MEM_BASE(MEM_BASE), .MEM_DEPTH(MEM_DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .s_axi (bus)
  );

  int n_compared = 0;
  int n_mismatched = 0;

  logic [7:0]  mdl [int unsigned];
  logic [31:0] wbuf [256];
  logic [3:0]  sbuf [256];
  logic        lbuf [256];
  logic [31:0] rdbuf [256];
  logic [1:0]  rrbuf [256];
  logic        rlbuf [256];
  logic [3:0]  ridbuf [256];
  logic [31:0] exp_d [256];
  logic [1:0]  exp_r [256];
  bit          exp_known [256];
  bit          pend_aw = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_compared++;
    assert (obs === expv) else begin
      n_mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] beat_addr(input logic [31:0] a, input logic [2:0] size,
                                            input logic [7:0] len, input logic [1:0] burst, input int i);
    longint unsigned step, base, wsize, lo;
    step = 64'd1 << size;
    base = a;
    if (burst == FIXED) return a;
    if (burst == WRAP) begin
      wsize = (longint'(len) + 1) * step;
      lo = base - (base % wsize);
      return 32'(lo + ((base - lo + longint'(i) * step) % wsize));
    end
    return 32'(base + longint'(i) * step);
  endfunction

  function automatic bit beat_bad(input logic [31:0] a, input logic [2:0] size,
                                  input logic [7:0] len, input logic [1:0] burst);
    bit wrap_legal;
    wrap_legal = 0;
`ifdef AXI_SLV_WRAP_EN
    wrap_legal = (len == 1) || (len == 3) || (len == 7) || (len == 15);
`endif
    return (longint'(a) < longint'(MEM_BASE)) || (longint'(a) >= longint'(MEM_BASE) + MEM_BYTES) ||
           (size > 2) || (burst == 2'b11) || ((burst == WRAP) && !wrap_legal);
  endfunction

  task automatic fill_wbuf(input logic [7:0] len, input logic [31:0] seed, input bit rand_data, input bit rand_strb);
    for (int i = 0; i <= int'(len); i++) begin
      wbuf[i] = rand_data ? $urandom : seed + 32'(i);
      sbuf[i] = rand_strb ? 4'($urandom_range(0, 15)) : 4'hF;
      lbuf[i] = (i == int'(len));
    end
  endtask

  task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst,
                          output logic [1:0] resp, output logic [3:0] bid_o);
    int cnt;
    @(negedge clk);
    bus.awid = id; bus.awaddr = addr; bus.awlen = len; bus.awsize = size; bus.awburst = burst;
    bus.awvalid = 1'b1;
    #1 cnt = 0;
    while (!bus.awready && cnt < TIMEOUT) begin @(negedge clk); #1 cnt++; end
    check("aw_accept_in_time", 64'(cnt < TIMEOUT), 1);
    @(posedge clk); #1 bus.awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      @(negedge clk);
      bus.wdata = wbuf[i]; bus.wstrb = sbuf[i]; bus.wlast = lbuf[i]; bus.wvalid = 1'b1;
      #1 cnt = 0;
      while (!bus.wready && cnt < TIMEOUT) begin @(negedge clk); #1 cnt++; end
      check($sformatf("w_accept_in_time[%0d]", i), 64'(cnt < TIMEOUT), 1);
      check($sformatf("no_bvalid_during_w[%0d]", i), 64'(bus.bvalid), 0);
      @(posedge clk); #1 bus.wvalid = 1'b0;
    end
    @(negedge clk);
    bus.bready = 1'b1;
    #1 cnt = 0;
    while (!bus.bvalid && cnt < TIMEOUT) begin @(negedge clk); #1 cnt++; end
    check("b_in_time", 64'(cnt < TIMEOUT), 1);
    resp = bus.bresp;
    bid_o = bus.bid;
    @(posedge clk); #1 bus.bready = 1'b0;
  endtask

  task automatic write_and_check(input string tag, input logic [3:0] id, input logic [31:0] addr,
                                 input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
    bit sticky;
    logic [31:0] ba, wa;
    logic [1:0] resp;
    logic [3:0] bid_o;
    sticky = 0;
    for (int i = 0; i <= int'(len); i++) begin
      ba = beat_addr(addr, size, len, burst, i);
      if (beat_bad(ba, size, len, burst)) sticky = 1;
      if (!sticky) begin
        wa = {ba[31:2], 2'b00};
        for (int b = 0; b < 4; b++) if (sbuf[i][b]) mdl[wa + 32'(b)] = wbuf[i][b*8 +: 8];
      end
      if (lbuf[i] != (i == int'(len))) sticky = 1;
    end
    do_write(id, addr, len, size, burst, resp, bid_o);
    check({tag, "_bresp"}, 64'(resp), sticky ? 2 : 0);
    check({tag, "_bid"}, 64'(bid_o), 64'(id));
  endtask

  task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst,
                         input int stall_beat, input int stall_cycles, output int lat);
    int cnt;
    @(negedge clk);
    bus.arid = id; bus.araddr = addr; bus.arlen = len; bus.arsize = size; bus.arburst = burst;
    bus.arvalid = 1'b1;
    if (pend_aw) bus.awvalid = 1'b1;
    #1 cnt = 0;
    while (!bus.arready && cnt < TIMEOUT) begin @(negedge clk); #1 cnt++; end
    check("ar_accept_in_time", 64'(cnt < TIMEOUT), 1);
    if (pend_aw) check("awready_low_when_ar_wins", 64'(bus.awready), 0);
    @(posedge clk); #1 bus.arvalid = 1'b0;
    bus.rready = 1'b1;
    lat = 0;
    for (int i = 0; i <= int'(len); i++) begin
      cnt = 0;
      do begin
        @(negedge clk); #1 cnt++;
        if (bus.awvalid) check("awready_low_during_read", 64'(bus.awready), 0);
      end while (!bus.rvalid && cnt < TIMEOUT);
      check($sformatf("r_in_time[%0d]", i), 64'(cnt < TIMEOUT), 1);
      if (i == 0) lat = cnt;
      rdbuf[i] = bus.rdata; rrbuf[i] = bus.rresp; rlbuf[i] = bus.rlast; ridbuf[i] = bus.rid;
      if (i == stall_beat) begin
        bus.rready = 1'b0;
        repeat (stall_cycles) begin
          @(negedge clk); #1;
          check($sformatf("rvalid_held[%0d]", i), 64'(bus.rvalid), 1);
          if (exp_known[i]) check($sformatf("rdata_stable[%0d]", i), 64'(bus.rdata), 64'(exp_d[i]));
        end
        bus.rready = 1'b1;
      end
      @(posedge clk);
    end
    #1 bus.rready = 1'b0;
  endtask

  task automatic read_and_check(input string tag, input logic [3:0] id, input logic [31:0] addr,
                                input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst,
                                input int stall_beat, input int stall_cycles, input bit check_lat);
    bit sticky;
    logic [31:0] ba, wa;
    int lat;
    sticky = 0;
    for (int i = 0; i <= int'(len); i++) begin
      ba = beat_addr(addr, size, len, burst, i);
      if (beat_bad(ba, size, len, burst)) sticky = 1;
      exp_r[i] = sticky ? 2'b10 : 2'b00;
      exp_known[i] = 1;
      exp_d[i] = '0;
      if (!sticky) begin
        wa = {ba[31:2], 2'b00};
        for (int b = 0; b < 4; b++) begin
          if (mdl.exists(wa + 32'(b))) exp_d[i][b*8 +: 8] = mdl[wa + 32'(b)];
          else exp_known[i] = 0;
        end
      end
    end
    do_read(id, addr, len, size, burst, stall_beat, stall_cycles, lat);
    if (check_lat) check({tag, "_first_rvalid_latency"}, 64'(lat), 2);
    for (int i = 0; i <= int'(len); i++) begin
      if (exp_known[i]) check($sformatf("%s_rdata[%0d]", tag, i), 64'(rdbuf[i]), 64'(exp_d[i]));
      check($sformatf("%s_rresp[%0d]", tag, i), 64'(rrbuf[i]), 64'(exp_r[i]));
      check($sformatf("%s_rlast[%0d]", tag, i), 64'(rlbuf[i]), 64'(i == int'(len)));
      check($sformatf("%s_rid[%0d]", tag, i), 64'(ridbuf[i]), 64'(id));
    end
  endtask

  initial begin
    logic [31:0] ra;
    logic [7:0]  rlen;
    logic [1:0]  rburst;

    rst_n = 1'b0;
    bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b0;
    bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arburst = '0; bus.arvalid = 1'b0;
    bus.rready = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    #1;
    check("rst_arready", 64'(bus.arready), 0);
    check("rst_awready", 64'(bus.awready), 0);
    check("rst_wready", 64'(bus.wready), 0);
    check("rst_bvalid", 64'(bus.bvalid), 0);
    check("rst_rvalid", 64'(bus.rvalid), 0);
    check("rst_rlast", 64'(bus.rlast), 0);
    check("rst_bid_rid", 64'({bus.bid, bus.rid}), 0);
    check("rst_resp", 64'({bus.bresp, bus.rresp}), 0);
    check("rst_rdata", 64'(bus.rdata), 0);
    @(negedge clk) rst_n = 1'b1;
    #1;
    check("idle_arready", 64'(bus.arready), 1);
    check("idle_awready", 64'(bus.awready), 1);

    // Single write then single read
    fill_wbuf(8'd0, 32'hDEAD_BEEF, 0, 0);
    write_and_check("single_wr", 4'd1, 32'h8000_0010, 8'd0, 3'd2, INCR);
    read_and_check("single_rd", 4'd3, 32'h8000_0010, 8'd0, 3'd2, INCR, -1, 0, 1);
    check("single_rd_value", 64'(rdbuf[0]), 64'h0000_0000_DEAD_BEEF);

    // INCR burst with a 5-cycle stall on beat 1
    fill_wbuf(8'd3, 32'd1, 0, 0);
    write_and_check("incr_wr", 4'd2, 32'h8000_0100, 8'd3, 3'd2, INCR);
    read_and_check("incr_rd", 4'd4, 32'h8000_0100, 8'd3, 3'd2, INCR, 1, 5, 1);

    // Partial strobe merge
    fill_wbuf(8'd0, 32'h1122_3344, 0, 0);
    write_and_check("strb_full_wr", 4'd1, 32'h8000_0020, 8'd0, 3'd2, INCR);
    fill_wbuf(8'd0, 32'hAABB_CCDD, 0, 0);
    sbuf[0] = 4'b0101;
    write_and_check("strb_part_wr", 4'd1, 32'h8000_0020, 8'd0, 3'd2, INCR);
    read_and_check("strb_rd", 4'd2, 32'h8000_0020, 8'd0, 3'd2, INCR, -1, 0, 0);
    check("strb_merged_word", 64'(rdbuf[0]), 64'h0000_0000_11BB_33DD);

    // Simultaneous AR and AW: read first, AW held and accepted afterwards
    bus.awid = 4'd6; bus.awaddr = 32'h8000_0040; bus.awlen = 8'd0; bus.awsize = 3'd2; bus.awburst = INCR;
    pend_aw = 1;
    read_and_check("race_rd", 4'd5, 32'h8000_0010, 8'd0, 3'd2, INCR, -1, 0, 0);
    pend_aw = 0;
    fill_wbuf(8'd0, 32'hCAFE_0001, 0, 0);
    write_and_check("race_wr", 4'd6, 32'h8000_0040, 8'd0, 3'd2, INCR);
    read_and_check("race_rdback", 4'd6, 32'h8000_0040, 8'd0, 3'd2, INCR, -1, 0, 0);

    // Error cases
    read_and_check("err_rd_low", 4'd1, 32'h7FFF_FFFC, 8'd0, 3'd2, INCR, -1, 0, 0);
    check("err_rd_low_rresp", 64'(rrbuf[0]), 2);
    fill_wbuf(8'd0, 32'h5A5A_5A5A, 0, 0);
    write_and_check("base_wr", 4'd1, MEM_BASE, 8'd0, 3'd2, INCR);
    fill_wbuf(8'd0, 32'h1234_5678, 0, 0);
    write_and_check("err_wr_top", 4'd2, MEM_BASE + 32'(MEM_BYTES), 8'd0, 3'd2, INCR);
    read_and_check("err_wr_top_untouched", 4'd2, MEM_BASE, 8'd0, 3'd2, INCR, -1, 0, 0);
    fill_wbuf(8'd3, 32'h0000_0A00, 0, 0);
    lbuf[1] = 1'b1; lbuf[3] = 1'b0;
    write_and_check("err_wlast", 4'd3, 32'h8000_0200, 8'd3, 3'd2, INCR);
    fill_wbuf(8'd1, 32'h0000_0F00, 0, 0);
    write_and_check("top_edge_wr", 4'd4, MEM_BASE + 32'(MEM_BYTES) - 32'd8, 8'd1, 3'd2, INCR);
    read_and_check("cross_top_rd", 4'd4, MEM_BASE + 32'(MEM_BYTES) - 32'd8, 8'd3, 3'd2, INCR, -1, 0, 0);
    read_and_check("err_size_rd", 4'd5, 32'h8000_0100, 8'd0, 3'd3, INCR, -1, 0, 0);
    read_and_check("err_rsvd_burst_rd", 4'd5, 32'h8000_0100, 8'd1, 3'd2, 2'b11, -1, 0, 0);

    // WRAP
    fill_wbuf(8'd3, 32'h0000_00A0, 0, 0);
    write_and_check("wrap_prep_wr", 4'd7, MEM_BASE, 8'd3, 3'd2, INCR);
    read_and_check("wrap_rd", 4'd7, 32'h8000_0008, 8'd3, 3'd2, WRAP, -1, 0, 0);
    fill_wbuf(8'd3, 32'h0000_00B0, 0, 0);
    write_and_check("wrap_wr", 4'd8, 32'h8000_0008, 8'd3, 3'd2, WRAP);
    read_and_check("wrap_wr_effect", 4'd8, MEM_BASE, 8'd3, 3'd2, INCR, -1, 0, 0);

    // Randomized bursts against the model
    for (int k = 0; k < 6; k++) begin
      ra = MEM_BASE + 32'h1000 + (32'($urandom_range(0, 1000)) << 2);
      rlen = 8'($urandom_range(0, 7));
      rburst = ($urandom_range(0, 1) == 1) ? INCR : FIXED;
      fill_wbuf(rlen, 32'd0, 1, 0);
      write_and_check($sformatf("rnd%0d_wr_full", k), 4'($urandom), ra, rlen, 3'd2, rburst);
      fill_wbuf(rlen, 32'd0, 1, 1);
      write_and_check($sformatf("rnd%0d_wr_part", k), 4'($urandom), ra, rlen, 3'd2, rburst);
      read_and_check($sformatf("rnd%0d_rd", k), 4'($urandom), ra, rlen, 3'd2, rburst,
                     $urandom_range(0, int'(rlen)), $urandom_range(0, 3), 0);
    end

    // Reset in the middle of a read burst
    @(negedge clk);
    bus.arid = 4'd9; bus.araddr = 32'h8000_0100; bus.arlen = 8'd3; bus.arsize = 3'd2; bus.arburst = INCR;
    bus.arvalid = 1'b1;
    #1 check("mid_rst_ar_ready", 64'(bus.arready), 1);
    @(posedge clk); #1 bus.arvalid = 1'b0;
    repeat (3) @(negedge clk);
    #1 check("mid_rst_rvalid_before", 64'(bus.rvalid), 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_rvalid", 64'(bus.rvalid), 0);
    check("mid_rst_rlast", 64'(bus.rlast), 0);
    check("mid_rst_bvalid", 64'(bus.bvalid), 0);
    check("mid_rst_arready", 64'(bus.arready), 0);
    @(negedge clk) rst_n = 1'b1;
    #1;
    check("post_rst_arready", 64'(bus.arready), 1);
    check("post_rst_rvalid", 64'(bus.rvalid), 0);
    read_and_check("post_rst_rd", 4'd10, 32'h8000_0100, 8'd3, 3'd2, INCR, -1, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
